vga_text_buffer: RTL
====================

VGA_TEXT_BUFFER -- requirements
Module: vga_text_buffer

Interface
REQ-001 clk  input  1  system clock; all logic sampled on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 iomem_valid  input  1  CPU bus request.
REQ-004 iomem_ready  output  1  one-cycle acknowledge, registered.
REQ-005 iomem_wstrb  input  4  byte write strobes; 0 = read.
REQ-006 iomem_addr  input  32  byte address.
REQ-007 iomem_wdata  input  32  write data.
REQ-008 iomem_rdata  output  32  read data, registered, valid when iomem_ready=1.
REQ-009 rd_col  input  7  renderer cell column, 0..79.
REQ-010 rd_row  input  5  renderer cell row, 0..29.
REQ-011 rd_char  output  8  character code at (rd_row, rd_col).
REQ-012 busy  output  1  clear sequence in progress.

Function
REQ-013 Storage: 80x30 grid of 8-bit cells, linear index row*80+col (0..2399), one write port (CPU/clear) and one read port (renderer).
REQ-014 Decode: select when iomem_addr[31:24]==8'h04; offset = iomem_addr[3:2]; other addresses never assert iomem_ready.
REQ-015 Handshake: accept when iomem_valid && !iomem_ready && selected; iomem_ready high exactly one cycle, in the cycle after acceptance; never high two consecutive cycles.
REQ-016 Offset 0 DATA write (wstrb[0]=1): wdata[7:0] processed as below; read returns {16'h0, 8'h0, 7'h0, busy}.
REQ-017 Printable char (not 0x0A, not 0x08): store at cursor, then col+1; col 79 -> col 0, row+1; row 29 -> row 0 (wrap, no scroll).
REQ-018 0x0A: no store; col=0, row+1 with same 29->0 wrap.
REQ-019 0x08: no store; col-1 if col>0, else unchanged.
REQ-020 Offset 1 CURSOR write: col=wdata[6:0], row=wdata[20:16]; col>79 clamps to 79, row>29 clamps to 29; read returns {11'h0, row, 9'h0, col}.
REQ-021 Offset 2 CTRL write wdata[0]=1: start clear; wdata[0]=0 ignored; read returns {31'h0, busy}.
REQ-022 Offset 3: write ignored, read returns 0, ready still given.
REQ-023 FSM states IDLE, CLEAR. IDLE -> CLEAR on CTRL start: busy=1, index=0, cursor=(0,0). CLEAR: write 0x20 at index each cycle, index+1; after writing 2399 -> IDLE, busy=0. Clear takes exactly 2400 cycles.
REQ-024 During CLEAR: DATA and CURSOR writes stall (iomem_ready withheld) until IDLE, then complete normally; reads and CTRL accesses acknowledge without stall; CTRL start during CLEAR ignored.
REQ-025 Renderer read: rd_char = cell(rd_row, rd_col) sampled one cycle earlier (1-cycle latency); out-of-range rd_col/rd_row give undefined data but no side effect.
REQ-026 Simultaneous write and renderer read of same cell: rd_char returns old contents (read-first).
REQ-027 Writes with wstrb[0]=0 but other strobes set on offsets 0/2 ignored; offset 1 uses wstrb[0] for col, wstrb[2] for row.

Reset
REQ-028 On reset: iomem_ready=0, iomem_rdata=0, busy=0, state IDLE, cursor (0,0), rd_char=0.
REQ-029 Reset during CLEAR aborts immediately; cells already written keep 0x20, remainder unchanged.
REQ-030 Cell RAM contents not initialised by reset.

Verification
REQ-031 Reset, write DATA 0x41 -> ready one cycle after valid; rd_row=0, rd_col=0 gives rd_char=0x41 next cycle; CURSOR read = 0x00000001.
REQ-032 CURSOR=(79,29), write 0x42 -> cell(29,79)=0x42, cursor reads 0x00000000.
REQ-033 CURSOR write wdata=0x001F007F -> clamps, reads 0x001D004F; DATA 0x0A -> cursor 0x00000000; 0x08 at col 0 -> unchanged.
REQ-034 CTRL=1 -> busy=1 for 2400 cycles, all cells 0x20; DATA write issued mid-clear gets ready only after busy falls and lands at (0,0).
REQ-035 Reset asserted 100 cycles into clear -> busy=0 next cycle, cells 0..99 = 0x20, cell 100 keeps prior value.
REQ-036 Address 0x05000000 access -> no ready for 10 cycles; offset 3 read -> ready with rdata 0.

Source files
------------

// File: rtl/vga_text_buffer_if.sv
// rtl/vga_text_buffer_if.sv - CPU memory-mapped bus bundle for the VGA text buffer
interface vga_text_buffer_if;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;

  modport master (
    output iomem_valid,
    output iomem_wstrb,
    output iomem_addr,
    output iomem_wdata,
    input  iomem_ready,
    input  iomem_rdata
  );

  modport slave (
    input  iomem_valid,
    input  iomem_wstrb,
    input  iomem_addr,
    input  iomem_wdata,
    output iomem_ready,
    output iomem_rdata
  );
endinterface

// File: rtl/vga_text_buffer.sv
// rtl/vga_text_buffer.sv - 80x30 character cell buffer with CPU cursor port, clear engine and renderer read port
module vga_text_buffer (
  input  logic              clk,
  input  logic              reset,
  vga_text_buffer_if.slave  cpu,
  input  logic [6:0]        rd_col,
  input  logic [4:0]        rd_row,
  output logic [7:0]        rd_char,
  output logic              busy
);

  localparam int unsigned CELLS = 2400;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t      state;
  logic [7:0]  mem [0:CELLS-1];
  logic [6:0]  cur_col;
  logic [4:0]  cur_row;
  logic [11:0] clr_idx;

  logic        sel;
  logic [1:0]  offset;
  logic        is_wr;
  logic        stall;
  logic        accept;
  logic [7:0]  ch;
  logic        data_wr;
  logic        cpu_store;
  logic [4:0]  row_inc;
  logic [6:0]  adv_col;
  logic [4:0]  adv_row;
  logic [6:0]  col_clamp;
  logic [4:0]  row_clamp;
  logic [11:0] cur_idx;
  logic [11:0] rd_idx;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [31:0] rd_val;
  logic        start_clear;
  logic        unused_bits;

  assign sel    = (cpu.iomem_addr[31:24] == 8'h04);
  assign offset = cpu.iomem_addr[3:2];
  assign is_wr  = |cpu.iomem_wstrb;
  // Cursor-moving writes wait for the clear to finish; reads and CTRL go straight through.
  assign stall  = (state == CLEAR) && is_wr && (offset == 2'd0 || offset == 2'd1);
  assign accept = cpu.iomem_valid && !cpu.iomem_ready && sel && !stall;

  assign ch          = cpu.iomem_wdata[7:0];
  assign data_wr     = accept && (offset == 2'd0) && cpu.iomem_wstrb[0];
  assign cpu_store   = data_wr && (ch != 8'h0A) && (ch != 8'h08);
  assign start_clear = accept && (offset == 2'd2) && cpu.iomem_wstrb[0] && cpu.iomem_wdata[0];
  assign cur_idx     = 12'(cur_row) * 12'd80 + 12'(cur_col);
  assign rd_idx      = 12'(rd_row) * 12'd80 + 12'(rd_col);
  assign col_clamp   = (cpu.iomem_wdata[6:0] > 7'd79) ? 7'd79 : cpu.iomem_wdata[6:0];
  assign row_clamp   = (cpu.iomem_wdata[20:16] > 5'd29) ? 5'd29 : cpu.iomem_wdata[20:16];
  assign unused_bits = ^{cpu.iomem_addr[23:4], cpu.iomem_addr[1:0],
                         cpu.iomem_wdata[31:21], cpu.iomem_wdata[15:8]};

  // Cursor movement for a DATA character: printable advances, LF starts next line, BS steps back.
  always_comb begin
    row_inc = (cur_row == 5'd29) ? 5'd0 : cur_row + 5'd1;
    adv_col = cur_col;
    adv_row = cur_row;
    case (ch)
      8'h0A: begin
        adv_col = 7'd0;
        adv_row = row_inc;
      end
      8'h08: begin
        if (cur_col != 7'd0) adv_col = cur_col - 7'd1;
      end
      default: begin
        if (cur_col == 7'd79) begin
          adv_col = 7'd0;
          adv_row = row_inc;
        end else begin
          adv_col = cur_col + 7'd1;
        end
      end
    endcase
  end

  // Single write port shared by the clear engine and CPU stores; reset suppresses the write.
  always_comb begin
    mem_we    = !reset && ((state == CLEAR) || cpu_store);
    mem_addr  = (state == CLEAR) ? clr_idx : cur_idx;
    mem_wdata = (state == CLEAR) ? 8'h20 : ch;
  end

  // Register read mux, captured into iomem_rdata on acceptance.
  always_comb begin
    rd_val = 32'h0;
    case (offset)
      2'd0:    rd_val = {31'h0, busy};
      2'd1:    rd_val = {11'h0, cur_row, 9'h0, cur_col};
      2'd2:    rd_val = {31'h0, busy};
      default: rd_val = 32'h0;
    endcase
  end

  // Cell storage write; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  // Renderer read port, one-cycle latency, returns old data on a same-cycle write.
  always_ff @(posedge clk) begin
    if (reset) rd_char <= 8'h00;
    else       rd_char <= mem[rd_idx];
  end

  // Control FSM: bus handshake, cursor state and the clear sweep.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      busy            <= 1'b0;
      clr_idx         <= 12'd0;
      cur_col         <= 7'd0;
      cur_row         <= 5'd0;
      cpu.iomem_ready <= 1'b0;
      cpu.iomem_rdata <= 32'h0;
    end else begin
      cpu.iomem_ready <= accept;
      if (accept) cpu.iomem_rdata <= rd_val;
      case (state)
        IDLE: begin
          if (data_wr) begin
            cur_col <= adv_col;
            cur_row <= adv_row;
          end
          if (accept && offset == 2'd1) begin
            if (cpu.iomem_wstrb[0]) cur_col <= col_clamp;
            if (cpu.iomem_wstrb[2]) cur_row <= row_clamp;
          end
          if (start_clear) begin
            state   <= CLEAR;
            busy    <= 1'b1;
            clr_idx <= 12'd0;
            cur_col <= 7'd0;
            cur_row <= 5'd0;
          end
        end
        CLEAR: begin
          clr_idx <= clr_idx + 12'd1;
          if (clr_idx == 12'(CELLS - 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
